// File: rtl/buffer_mc_pkg.sv
// Shared sizing helpers for the multi-channel FIFO buffer.
package buffer_mc_pkg;

  function automatic int depth_of(input int addr_l);
    return 1 << addr_l;
  endfunction

  // Occupancy needs one extra bit so that a completely full channel is distinct from empty.
  function automatic int cnt_w(input int addr_l);
    return addr_l + 1;
  endfunction

endpackage

// File: rtl/buffer_mc_ch.sv
// One FIFO channel: storage, wrapping pointers, occupancy, sticky error flags and handshake acks.
module buffer_mc_ch
  import buffer_mc_pkg::*;
#(
  parameter int ADDR_L   = 4,
  parameter int DATA_L   = 16,
  parameter int AFULL_TH = depth_of(ADDR_L) - 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [DATA_L-1:0]         din,
  input  logic                      re,
  input  logic                      flush,
  input  logic                      err_clr,
  output logic [DATA_L-1:0]         dout,
  output logic                      r_ack,
  output logic                      w_ack,
  output logic                      avail,
  output logic                      full,
  output logic                      afull,
  output logic [cnt_w(ADDR_L)-1:0]  count,
  output logic                      ovf,
  output logic                      udf
);

  localparam int DEPTH = depth_of(ADDR_L);
  localparam int CW    = cnt_w(ADDR_L);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] TH_CNT   = CW'(AFULL_TH);

  logic [DATA_L-1:0] mem [DEPTH];
  logic [ADDR_L-1:0] rpt;
  logic [ADDR_L-1:0] wpt;
  logic [CW-1:0]     cnt;
  logic              wr_ok;
  logic              rd_ok;
  logic              ovf_ev;
  logic              udf_ev;

  assign full  = (cnt == FULL_CNT);
  assign avail = (cnt != '0);
  assign afull = (cnt >= TH_CNT);
  assign count = cnt;

  // A full channel still takes a write when a read frees a slot in the same cycle.
  assign wr_ok  = we && (!full || re) && !flush;
  assign rd_ok  = re && avail && !flush;
  assign ovf_ev = we && full && !re && !flush;
  assign udf_ev = re && !avail && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rpt   <= '0;
      wpt   <= '0;
      cnt   <= '0;
      dout  <= '0;
      r_ack <= 1'b0;
      w_ack <= 1'b0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      r_ack <= rd_ok;
      w_ack <= wr_ok;
      // A new error event outranks err_clr in the same cycle.
      ovf   <= ovf_ev | (ovf & ~err_clr);
      udf   <= udf_ev | (udf & ~err_clr);
      if (flush) begin
        rpt <= '0;
        wpt <= '0;
        cnt <= '0;
      end else begin
        if (wr_ok) wpt <= wpt + 1'b1;
        if (rd_ok) begin
          rpt  <= rpt + 1'b1;
          dout <= mem[rpt];
        end
        case ({wr_ok, rd_ok})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  // Storage is never cleared; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) mem[wpt] <= din;
  end

endmodule

// File: rtl/buffer_mc.sv
// Multi-channel synchronous FIFO: CH_N independent channels sharing clock, reset and err_clr.
module buffer_mc
  import buffer_mc_pkg::*;
#(
  parameter int BUF_ID   = 0,
  parameter int CH_N     = 4,
  parameter int ADDR_L   = 4,
  parameter int DATA_L   = 16,
  parameter int AFULL_TH = depth_of(ADDR_L) - 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CH_N-1:0]                 we,
  input  logic [CH_N*DATA_L-1:0]          din,
  input  logic [CH_N-1:0]                 re,
  input  logic [CH_N-1:0]                 flush,
  input  logic                            err_clr,
  output logic [CH_N*DATA_L-1:0]          dout,
  output logic [CH_N-1:0]                 r_ack,
  output logic [CH_N-1:0]                 w_ack,
  output logic [CH_N-1:0]                 avail,
  output logic [CH_N-1:0]                 full,
  output logic [CH_N-1:0]                 afull,
  output logic [CH_N*cnt_w(ADDR_L)-1:0]   count,
  output logic [CH_N-1:0]                 ovf,
  output logic [CH_N-1:0]                 udf
);

  localparam int CW = cnt_w(ADDR_L);

  if (CH_N < 1 || CH_N > 16 || BUF_ID < 0) begin : g_bad_cfg
    $error("buffer_mc %0d: CH_N must be 1..16", BUF_ID);
  end

  for (genvar c = 0; c < CH_N; c++) begin : g_ch
    buffer_mc_ch #(
      .ADDR_L   (ADDR_L),
      .DATA_L   (DATA_L),
      .AFULL_TH (AFULL_TH)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (we[c]),
      .din     (din[c*DATA_L +: DATA_L]),
      .re      (re[c]),
      .flush   (flush[c]),
      .err_clr (err_clr),
      .dout    (dout[c*DATA_L +: DATA_L]),
      .r_ack   (r_ack[c]),
      .w_ack   (w_ack[c]),
      .avail   (avail[c]),
      .full    (full[c]),
      .afull   (afull[c]),
      .count   (count[c*CW +: CW]),
      .ovf     (ovf[c]),
      .udf     (udf[c])
    );
  end

endmodule

// File: tb/tb_buffer_mc.sv
// Directed plus randomized bench for buffer_mc against a queue-based reference model.
module tb_buffer_mc;

  localparam int CH_N     = 4;
  localparam int ADDR_L   = 2;
  localparam int DATA_L   = 16;
  localparam int DEPTH    = 4;
  localparam int AFULL_TH = 2;
  localparam int CW       = 3;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [CH_N-1:0]        we, re, flush;
  logic [CH_N*DATA_L-1:0] din;
  logic                   err_clr;
  logic [CH_N*DATA_L-1:0] dout;
  logic [CH_N-1:0]        r_ack, w_ack, avail, full, afull, ovf, udf;
  logic [CH_N*CW-1:0]     count;

  always #5 clk = ~clk;

  buffer_mc #(
    .BUF_ID(7), .CH_N(CH_N), .ADDR_L(ADDR_L), .DATA_L(DATA_L), .AFULL_TH(AFULL_TH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .din(din), .re(re), .flush(flush),
    .err_clr(err_clr), .dout(dout), .r_ack(r_ack), .w_ack(w_ack), .avail(avail),
    .full(full), .afull(afull), .count(count), .ovf(ovf), .udf(udf)
  );

  // Reference model: one queue per channel plus the visible registers.
  logic [DATA_L-1:0] q [CH_N][$];
  logic [DATA_L-1:0] m_dout [CH_N];
  bit m_rack [CH_N];
  bit m_wack [CH_N];
  bit m_ovf  [CH_N];
  bit m_udf  [CH_N];

  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    for (int c = 0; c < CH_N; c++) begin
      int n;
      bit r, w;
      n = q[c].size();
      if (!rst_n) begin
        q[c].delete();
        m_dout[c] = '0;
        m_rack[c] = 0; m_wack[c] = 0; m_ovf[c] = 0; m_udf[c] = 0;
      end else if (flush[c]) begin
        q[c].delete();
        m_rack[c] = 0; m_wack[c] = 0;
        m_ovf[c] = m_ovf[c] && !err_clr;
        m_udf[c] = m_udf[c] && !err_clr;
      end else begin
        r = re[c] && (n > 0);
        w = we[c] && ((n < DEPTH) || re[c]);
        m_ovf[c] = (we[c] && !w) || (m_ovf[c] && !err_clr);
        m_udf[c] = (re[c] && n == 0) || (m_udf[c] && !err_clr);
        if (r) m_dout[c] = q[c].pop_front();
        if (w) q[c].push_back(din[c*DATA_L +: DATA_L]);
        m_rack[c] = r;
        m_wack[c] = w;
      end
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < CH_N; c++) begin
      int n;
      n = q[c].size();
      chk($sformatf("count%0d", c), 32'(count[c*CW +: CW]), 32'(n));
      chk($sformatf("avail%0d", c), 32'(avail[c]), 32'(n != 0));
      chk($sformatf("full%0d", c),  32'(full[c]),  32'(n == DEPTH));
      chk($sformatf("afull%0d", c), 32'(afull[c]), 32'(n >= AFULL_TH));
      chk($sformatf("dout%0d", c),  32'(dout[c*DATA_L +: DATA_L]), 32'(m_dout[c]));
      chk($sformatf("r_ack%0d", c), 32'(r_ack[c]), 32'(m_rack[c]));
      chk($sformatf("w_ack%0d", c), 32'(w_ack[c]), 32'(m_wack[c]));
      chk($sformatf("ovf%0d", c),   32'(ovf[c]),   32'(m_ovf[c]));
      chk($sformatf("udf%0d", c),   32'(udf[c]),   32'(m_udf[c]));
    end
  endtask

  task automatic idle();
    we = '0; re = '0; flush = '0; err_clr = 1'b0; rst_n = 1'b1; din = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    check_all();
    idle();
  endtask

  task automatic wr(input int c, input logic [DATA_L-1:0] d);
    we[c] = 1'b1;
    din[c*DATA_L +: DATA_L] = d;
    cycle();
  endtask

  task automatic rd(input int c);
    re[c] = 1'b1;
    cycle();
  endtask

  logic [DATA_L-1:0] last;

  initial begin
    idle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b0;
    cycle();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dout", 32'(dout[31:0]), 32'd0);

    // Basic ordered write/read on ch1.
    wr(1, 16'h0011); wr(1, 16'h0022); wr(1, 16'h0033);
    chk("basic_cnt3", 32'(count[1*CW +: CW]), 32'd3);
    rd(1); chk("basic_rd0", 32'(dout[16 +: 16]), 32'h11); chk("basic_ack0", 32'(r_ack[1]), 32'd1);
    rd(1); chk("basic_rd1", 32'(dout[16 +: 16]), 32'h22);
    rd(1); chk("basic_rd2", 32'(dout[16 +: 16]), 32'h33);
    chk("basic_cnt0", 32'(count[1*CW +: CW]), 32'd0);
    cycle(); chk("basic_ack_drop", 32'(r_ack[1]), 32'd0);

    // Fill ch0, overflow, drain.
    for (int i = 0; i < DEPTH; i++) wr(0, 16'hA0 + 16'(i));
    chk("fill_full", 32'(full[0]), 32'd1);
    wr(0, 16'h00EE);
    chk("ovf_noack", 32'(w_ack[0]), 32'd0);
    chk("ovf_flag", 32'(ovf[0]), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      rd(0);
      chk("ovf_drain", 32'(dout[0 +: 16]), 32'(16'hA0 + 16'(i)));
    end

    // Simultaneous read+write at full on ch0.
    for (int i = 0; i < DEPTH; i++) wr(0, 16'hB0 + 16'(i));
    re[0] = 1'b1; we[0] = 1'b1; din[0 +: 16] = 16'h00B4;
    cycle();
    chk("full_rw_cnt", 32'(count[0 +: CW]), 32'd4);
    chk("full_rw_dout", 32'(dout[0 +: 16]), 32'hB0);

    // Simultaneous read+write at empty on ch3.
    last = dout[48 +: 16];
    re[3] = 1'b1; we[3] = 1'b1; din[48 +: 16] = 16'h0333;
    cycle();
    chk("empty_rw_cnt", 32'(count[3*CW +: CW]), 32'd1);
    chk("empty_rw_udf", 32'(udf[3]), 32'd1);
    chk("empty_rw_rack", 32'(r_ack[3]), 32'd0);
    chk("empty_rw_dout", 32'(dout[48 +: 16]), 32'(last));

    // err_clr loses to a same-cycle underflow, then clears alone.
    rd(3);
    re[3] = 1'b1; err_clr = 1'b1;
    cycle();
    chk("errclr_hold", 32'(udf[3]), 32'd1);
    err_clr = 1'b1;
    cycle();
    chk("errclr_clear", 32'(udf[3]), 32'd0);

    // Wrap on ch2.
    for (int i = 0; i < 10; i++) begin
      wr(2, 16'(i));
      rd(2);
      chk("wrap_data", 32'(dout[32 +: 16]), 32'(i));
    end
    chk("wrap_noerr", 32'({ovf[2], udf[2]}), 32'd0);

    // Flush with concurrent requests, then mid-stream reset.
    wr(1, 16'h0101); wr(1, 16'h0102); wr(1, 16'h0103);
    flush[1] = 1'b1; we[1] = 1'b1; re[1] = 1'b1; din[16 +: 16] = 16'h0BAD;
    cycle();
    chk("flush_cnt", 32'(count[1*CW +: CW]), 32'd0);
    chk("flush_acks", 32'({r_ack[1], w_ack[1]}), 32'd0);
    wr(1, 16'h0201); wr(1, 16'h0202);
    rst_n = 1'b0;
    cycle();
    chk("rst_mid_cnt", 32'(count), 32'd0);
    chk("rst_mid_dout", 32'(dout[63:32]), 32'd0);
    chk("rst_mid_flags", 32'({ovf, udf}), 32'd0);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      we = CH_N'($urandom);
      re = CH_N'($urandom);
      din = {$urandom, $urandom};
      for (int c = 0; c < CH_N; c++) flush[c] = ($urandom_range(0, 19) == 0);
      err_clr = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
